// File: rtl/vga_layer_mixer_if.sv
// Pixel-path bundle between the sync generator side and vga_layer_mixer.
// master: the surrounding logic that drives pixels/syncs and receives the mixed output.
// slave : the mixer itself.
interface vga_layer_mixer_if #(
  parameter int unsigned NUM_LAYERS  = 4,
  parameter int unsigned NUM_BG      = 4,
  parameter int unsigned COLOR_W     = 2,
  parameter int unsigned FRAME_CNT_W = 10
);
  localparam int unsigned PIX_W = 3 * COLOR_W;
  localparam int unsigned SEL_W = (NUM_BG > 1) ? $clog2(NUM_BG) : 1;

  logic                          hsync_in;
  logic                          vsync_in;
  logic                          display_on_in;
  logic [NUM_LAYERS-1:0]         layer_valid;
  logic [NUM_LAYERS*PIX_W-1:0]   layer_rgb;
  logic [NUM_BG*PIX_W-1:0]       bg_rgb;
  logic [SEL_W-1:0]              bg_sel_req;

  logic [COLOR_W-1:0]            R;
  logic [COLOR_W-1:0]            G;
  logic [COLOR_W-1:0]            B;
  logic                          hsync;
  logic                          vsync;
  logic [SEL_W-1:0]              bg_sel_active;
  logic                          fade_busy;
  logic [FRAME_CNT_W-1:0]        frame_cnt;

  modport master (
    output hsync_in, vsync_in, display_on_in, layer_valid, layer_rgb, bg_rgb, bg_sel_req,
    input  R, G, B, hsync, vsync, bg_sel_active, fade_busy, frame_cnt
  );

  modport slave (
    input  hsync_in, vsync_in, display_on_in, layer_valid, layer_rgb, bg_rgb, bg_sel_req,
    output R, G, B, hsync, vsync, bg_sel_active, fade_busy, frame_cnt
  );
endinterface

// File: rtl/vga_layer_mixer.sv
// Two-stage pixel compositor: priority sprite layers over a selectable background,
// with frame-synchronous fade-out / swap / fade-in when the background changes.
// Syncs are delayed alongside the colour so both leave after exactly 2 clocks.
// Optional: define VGA_LAYER_MIXER_COLOR_KEY_EN to make all-zero layer pixels transparent.
module vga_layer_mixer #(
  parameter int unsigned NUM_LAYERS      = 4,
  parameter int unsigned NUM_BG          = 4,
  parameter int unsigned COLOR_W         = 2,
  parameter int unsigned FRAMES_PER_STEP = 4,
  parameter int unsigned FRAME_CNT_W     = 10
) (
  input logic               clk,
  input logic               reset,
  vga_layer_mixer_if.slave  bus
);
  localparam int unsigned PIX_W    = 3 * COLOR_W;
  localparam int unsigned SEL_W    = (NUM_BG > 1) ? $clog2(NUM_BG) : 1;
  localparam int unsigned LVL_W    = $clog2(COLOR_W + 1);
  localparam int unsigned DIV_W    = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam int unsigned BG_LAST  = NUM_BG - 1;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_FADE_OUT = 2'd1;
  localparam logic [1:0] ST_SWAP     = 2'd2;
  localparam logic [1:0] ST_FADE_IN  = 2'd3;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(FRAMES_PER_STEP - 1);
  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(COLOR_W);
  localparam logic [LVL_W-1:0] LVL_ONE   = LVL_W'(1);
  localparam logic [LVL_W-1:0] LVL_PRE   = LVL_W'(COLOR_W - 1);

  logic [1:0]             state_q, state_d;
  logic [LVL_W-1:0]       level_q, level_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic [SEL_W-1:0]       sel_q, sel_d;
  logic                   busy_q;
  logic [FRAME_CNT_W-1:0] frame_cnt_q;

  logic                   vs_hist_q;
  logic                   hs1_q, vs1_q, de1_q;
  logic [PIX_W-1:0]       rgb1_q;
  logic                   hs2_q, vs2_q;
  logic [PIX_W-1:0]       rgb2_q;

  logic                   tick_c;
  logic [SEL_W-1:0]       req_c;
  logic [PIX_W-1:0]       bg_pix_c;
  logic [PIX_W-1:0]       bg_fade_c;
  logic [PIX_W-1:0]       pix1_c;
  logic [LVL_W-1:0]       shamt_c;

  // Frame tick on the falling edge of the registered vsync
  assign tick_c = vs_hist_q & ~vs1_q;

  // Out-of-range requests select the last background
  assign req_c = (32'(bus.bg_sel_req) > BG_LAST) ? SEL_W'(BG_LAST) : bus.bg_sel_req;

  // Fade state machine: next-state, advances only on frame ticks
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    div_d   = div_q;
    sel_d   = sel_q;
    if (tick_c) begin
      case (state_q)
        ST_IDLE: begin
          if (req_c != sel_q) begin
            state_d = ST_FADE_OUT;
            div_d   = '0;
          end
        end
        ST_FADE_OUT: begin
          if (div_q == DIV_LAST) begin
            div_d   = '0;
            level_d = level_q - LVL_ONE;
            if (level_q == LVL_ONE) state_d = ST_SWAP;
          end else begin
            div_d = div_q + DIV_W'(1);
          end
        end
        ST_SWAP: begin
          sel_d   = req_c;
          state_d = ST_FADE_IN;
        end
        ST_FADE_IN: begin
          if (div_q == DIV_LAST) begin
            div_d   = '0;
            level_d = level_q + LVL_ONE;
            if (level_q == LVL_PRE) state_d = ST_IDLE;
          end else begin
            div_d = div_q + DIV_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Fade state, background selection and frame counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      level_q     <= LVL_FULL;
      div_q       <= '0;
      sel_q       <= '0;
      busy_q      <= 1'b0;
      frame_cnt_q <= '0;
      vs_hist_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      div_q     <= div_d;
      sel_q     <= sel_d;
      busy_q    <= (state_d != ST_IDLE);
      vs_hist_q <= vs1_q;
      if (tick_c) frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
    end
  end

  // Active background pixel, attenuated by the current fade level
  always_comb begin
    bg_pix_c = '0;
    for (int unsigned j = 0; j < NUM_BG; j++) begin
      if (SEL_W'(j) == sel_q) bg_pix_c = bus.bg_rgb[j*PIX_W +: PIX_W];
    end
    shamt_c = LVL_FULL - level_q;
    for (int unsigned c = 0; c < 3; c++) begin
      bg_fade_c[c*COLOR_W +: COLOR_W] = bg_pix_c[c*COLOR_W +: COLOR_W] >> shamt_c;
    end
  end

  // Priority layer search; lowest index wins, background fills the rest
  always_comb begin
    logic hit;
    logic opaque;
    hit    = 1'b0;
    opaque = 1'b0;
    pix1_c = bg_fade_c;
    for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
`ifdef VGA_LAYER_MIXER_COLOR_KEY_EN
      opaque = bus.layer_valid[i] && (|bus.layer_rgb[i*PIX_W +: PIX_W]);
`else
      opaque = bus.layer_valid[i];
`endif
      if (!hit && opaque) begin
        pix1_c = bus.layer_rgb[i*PIX_W +: PIX_W];
        hit    = 1'b1;
      end
    end
  end

  // Stage 1: composed colour plus display-enable and syncs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb1_q <= '0;
      de1_q  <= 1'b0;
      hs1_q  <= 1'b1;
      vs1_q  <= 1'b1;
    end else begin
      rgb1_q <= pix1_c;
      de1_q  <= bus.display_on_in;
      hs1_q  <= bus.hsync_in;
      vs1_q  <= bus.vsync_in;
    end
  end

  // Stage 2: blank outside the visible area, forward syncs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb2_q <= '0;
      hs2_q  <= 1'b1;
      vs2_q  <= 1'b1;
    end else begin
      rgb2_q <= de1_q ? rgb1_q : '0;
      hs2_q  <= hs1_q;
      vs2_q  <= vs1_q;
    end
  end

  assign bus.R             = rgb2_q[2*COLOR_W +: COLOR_W];
  assign bus.G             = rgb2_q[COLOR_W +: COLOR_W];
  assign bus.B             = rgb2_q[0 +: COLOR_W];
  assign bus.hsync         = hs2_q;
  assign bus.vsync         = vs2_q;
  assign bus.bg_sel_active = sel_q;
  assign bus.fade_busy     = busy_q;
  assign bus.frame_cnt     = frame_cnt_q;
endmodule

// File: doc/vga_layer_mixer.md
Name: vga_layer_mixer

Overview:
- Parametrised pixel compositor between the sync generator and the TinyVGA PMOD output mapping.
- Merges NUM_LAYERS priority-ordered sprite layers over one of NUM_BG background sources.
- Background switching is frame-synchronous, with a fade-to-black / fade-in transition.
- Delays hsync/vsync by the same pipeline depth as the pixels, so colour and sync stay aligned.

Parameters:
- NUM_LAYERS, 4, sprite layers; index 0 = highest priority.
- NUM_BG, 4, background sources selectable at run time.
- COLOR_W, 2, bits per colour channel.
- FRAMES_PER_STEP, 4, frame ticks per fade level step (>=1).
- FRAME_CNT_W, 10, width of the free-running frame counter.

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- hsync_in  in  1  active-low horizontal sync from generator
- vsync_in  in  1  active-low vertical sync from generator
- display_on_in  in  1  high inside the visible area
- layer_valid  in  NUM_LAYERS  per-layer opaque-pixel flag
- layer_rgb  in  NUM_LAYERS*3*COLOR_W  per layer {R,G,B}; layer i at bits [i*3*COLOR_W +: 3*COLOR_W]
- bg_rgb  in  NUM_BG*3*COLOR_W  per background {R,G,B}, same packing
- bg_sel_req  in  max(1,$clog2(NUM_BG))  requested background index
- R, G, B  out  COLOR_W each  registered colour
- hsync, vsync  out  1  sync delayed to match colour
- bg_sel_active  out  same width as bg_sel_req  background currently displayed
- fade_busy  out  1  high while not IDLE
- frame_cnt  out  FRAME_CNT_W  frame tick counter, wraps

Behaviour:
- Reset (async, active-high):
  - R/G/B = 0; hsync = vsync = 1.
  - bg_sel_active = 0; fade_busy = 0; frame_cnt = 0.
  - level = COLOR_W; FSM = IDLE; div = 0.
  - Internal vsync history = 1, so no tick is generated on reset release.
- Frame tick: one-cycle pulse when registered vsync_in goes 1->0. frame_cnt increments on each tick and wraps modulo 2^FRAME_CNT_W.
- Stage 1 (cycle 1):
  - Layer selection: the lowest index i with layer_valid[i]=1 wins.
  - If no layer is valid, the pixel is bg_rgb[bg_sel_active].
  - Background faded value per channel = c >> (COLOR_W - level). Layers are never faded.
  - Stage 1 also registers display_on, hsync and vsync.
- Stage 2 (cycle 2):
  - If the registered display_on = 0, R/G/B = 0; otherwise the stage-1 colour.
  - Sync outputs are the stage-1 syncs.
  - Total latency for colour and sync is exactly 2 clocks.
- FSM (state advances only on frame ticks):
  - IDLE: on a tick with bg_sel_req != bg_sel_active -> FADE_OUT, div = 0.
  - FADE_OUT: each tick, div++. When div reaches FRAMES_PER_STEP-1: div = 0, level--.
  - When level becomes 0 -> SWAP.
  - SWAP: on the next tick, bg_sel_active <= bg_sel_req (sampled on that tick) -> FADE_IN.
  - FADE_IN: same stepping rule as FADE_OUT but level++. When level reaches COLOR_W -> IDLE.
  - bg_sel_req changes during FADE_OUT or FADE_IN are ignored; IDLE re-evaluates on the next tick, so a further differing request starts a new fade.
- bg_sel_req >= NUM_BG is treated as index NUM_BG-1.
- bg_sel_active only changes in SWAP, so there is no mid-frame tearing.
- Reset asserted mid-fade: immediate return to the reset values. The fade is abandoned; the first background is shown at full level.
- fade_busy = (state != IDLE), registered.

Optional Feature:
- Macro: VGA_LAYER_MIXER_COLOR_KEY_EN.
- Defined:
  - A valid layer whose {R,G,B} equals all zeros is transparent.
  - Priority search continues to the next layer, then to the background.
  - True black sprite pixels are therefore not drawable.
- Undefined: layer_valid alone decides opacity; black layer pixels are drawn.

Test Plan:
- Latency: reset, then drive display_on_in=1, no layers, bg_rgb[0]={2'b00,2'b01,2'b11}.
  - R/G/B = 00/01/11 appear exactly 2 clocks after input; hsync/vsync are also delayed by 2.
  - display_on_in=0 -> R/G/B = 0 two clocks later.
- Priority: layer_valid=4'b0110 with layer1=3F-pattern {11,11,11} and layer2={01,00,00} -> output {11,11,11}.
  - layer_valid=0 -> background colour.
- Fade with FRAMES_PER_STEP=1, COLOR_W=2: bg0={11,11,11}, bg_sel_req=1 from frame 0.
  - Background level sequence per frame: 3 (11), then 01 (level 1), 00 (level 0).
  - Then swap: bg_sel_active=1 at the next tick.
  - Then fade-in to full; fade_busy is high throughout; a sprite pixel stays {11,11,11} during the fade.
- Request during fade: toggle bg_sel_req 1->2 mid FADE_OUT -> swap lands on 2.
  - Set bg_sel_req back to 0 during FADE_IN -> FSM returns to IDLE, then on the next tick starts a new FADE_OUT.
- Reset mid-fade: assert reset in FADE_IN -> same cycle R/G/B=0, hsync=vsync=1, bg_sel_active=0, fade_busy=0, frame_cnt=0.
- Color key (macro defined): layer0 valid, rgb=0; layer1 valid, rgb={10,10,10} -> output {10,10,10}.
  - Macro undefined -> output 0.
